// File: rtl/instruction_decode_queue_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for instruction_decode_queue.
// The `illegal` field is present only when ILLEGAL_DETECT_EN is defined.
// master: the decode queue itself; slave: the surrounding fetch/execute logic.
interface instruction_decode_queue_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
`ifdef ILLEGAL_DETECT_EN
    logic            illegal;
`endif

    modport master (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, funct3, funct7,
               rs1, rs2, rd, imm
`ifdef ILLEGAL_DETECT_EN
        , output illegal
`endif
    );

    modport slave (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, funct3, funct7,
               rs1, rs2, rd, imm
`ifdef ILLEGAL_DETECT_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/instruction_decode_queue.sv
// instruction_decode_queue: combinational RV decode of the incoming instruction,
// buffered in a BUF_DEPTH-entry FIFO with valid/ready on both sides and a
// synchronous flush. The head entry is held in dedicated output registers that
// are cleared by reset and otherwise keep their last value while the queue is empty.
// Optional feature macro: ILLEGAL_DETECT_EN (adds per-entry `illegal` flag).
module instruction_decode_queue #(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_decode_queue_if.master bus
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    // Sign-extend a 32-bit immediate to the datapath width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0]     s;
        logic signed [XLEN-1:0] w;
        s = v;
        w = s;
        return w;
    endfunction

    logic [31:0]     instr_s;
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] dec_imm_s;
`ifdef ILLEGAL_DETECT_EN
    logic            op_ok_s;
    logic            dec_ill_s;
`endif

    logic            push_s;
    logic            pop_s;
    logic            bypass_s;
    logic            load_head_s;
    logic [PTR_W-1:0] wr_nxt_s;
    logic [PTR_W-1:0] rd_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [XLEN-1:0] mem_pc_r    [BUF_DEPTH];
    logic [31:0]     mem_instr_r [BUF_DEPTH];
    logic [XLEN-1:0] mem_imm_r   [BUF_DEPTH];
`ifdef ILLEGAL_DETECT_EN
    logic            mem_ill_r   [BUF_DEPTH];
`endif

    logic [XLEN-1:0] head_pc_r;
    logic [31:0]     head_instr_r;
    logic [XLEN-1:0] head_imm_r;
`ifdef ILLEGAL_DETECT_EN
    logic            head_ill_r;
`endif

    assign instr_s = bus.in_instr;

    // Immediate extraction by opcode format (R and unknown opcodes give zero).
    always_comb begin
        imm32_s = 32'd0;
        case (instr_s[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
                imm32_s = {{20{instr_s[31]}}, instr_s[31:20]};
            7'b0100011:
                imm32_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
            7'b1100011:
                imm32_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7],
                           instr_s[30:25], instr_s[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32_s = {instr_s[31:12], 12'd0};
            7'b1101111:
                imm32_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12],
                           instr_s[20], instr_s[30:21], 1'b0};
            default:
                imm32_s = 32'd0;
        endcase
    end

`ifdef ILLEGAL_DETECT_EN
    // Legality check; illegal entries still queue but carry a zero immediate.
    always_comb begin
        op_ok_s = 1'b0;
        case (instr_s[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011,
            7'b0001111: op_ok_s = 1'b1;
            default:    op_ok_s = 1'b0;
        endcase
        dec_ill_s = ~op_ok_s | (instr_s[1:0] != 2'b11);
        dec_imm_s = dec_ill_s ? {XLEN{1'b0}} : sext32(imm32_s);
    end
`else
    assign dec_imm_s = sext32(imm32_s);
`endif

    // Handshake qualification and next-state of pointers/count (flush wins).
    always_comb begin
        push_s = bus.in_valid & in_ready_r & ~bus.flush;
        pop_s  = out_valid_r & bus.out_ready & ~bus.flush;
        if (bus.flush) begin
            wr_nxt_s  = {PTR_W{1'b0}};
            rd_nxt_s  = {PTR_W{1'b0}};
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            wr_nxt_s  = wr_ptr_r + PTR_W'(push_s);
            rd_nxt_s  = rd_ptr_r + PTR_W'(pop_s);
            cnt_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
        // If nothing older survives this cycle, the new head is the entry being pushed.
        bypass_s    = ((count_r - CNT_W'(pop_s)) == {CNT_W{1'b0}});
        load_head_s = ~bus.flush & (cnt_nxt_s != {CNT_W{1'b0}});
    end

    // Queue control registers; in_ready/out_valid are registered copies of count state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_nxt_s;
            rd_ptr_r    <= rd_nxt_s;
            count_r     <= cnt_nxt_s;
            in_ready_r  <= (cnt_nxt_s < DEPTH_C);
            out_valid_r <= (cnt_nxt_s != {CNT_W{1'b0}});
        end
    end

    // Payload storage, written at push; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_r[wr_ptr_r]    <= bus.in_pc;
            mem_instr_r[wr_ptr_r] <= instr_s;
            mem_imm_r[wr_ptr_r]   <= dec_imm_s;
`ifdef ILLEGAL_DETECT_EN
            mem_ill_r[wr_ptr_r]   <= dec_ill_s;
`endif
        end
    end

    // Head output registers: load the next head, otherwise hold; zero on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_pc_r    <= {XLEN{1'b0}};
            head_instr_r <= 32'd0;
            head_imm_r   <= {XLEN{1'b0}};
`ifdef ILLEGAL_DETECT_EN
            head_ill_r   <= 1'b0;
`endif
        end else if (load_head_s) begin
            if (bypass_s) begin
                head_pc_r    <= bus.in_pc;
                head_instr_r <= instr_s;
                head_imm_r   <= dec_imm_s;
`ifdef ILLEGAL_DETECT_EN
                head_ill_r   <= dec_ill_s;
`endif
            end else begin
                head_pc_r    <= mem_pc_r[rd_nxt_s];
                head_instr_r <= mem_instr_r[rd_nxt_s];
                head_imm_r   <= mem_imm_r[rd_nxt_s];
`ifdef ILLEGAL_DETECT_EN
                head_ill_r   <= mem_ill_r[rd_nxt_s];
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_pc    = head_pc_r;
    assign bus.opcode    = head_instr_r[6:0];
    assign bus.rd        = head_instr_r[11:7];
    assign bus.funct3    = head_instr_r[14:12];
    assign bus.rs1       = head_instr_r[19:15];
    assign bus.rs2       = head_instr_r[24:20];
    assign bus.funct7    = head_instr_r[31:25];
    assign bus.imm       = head_imm_r;
`ifdef ILLEGAL_DETECT_EN
    assign bus.illegal   = head_ill_r;
`endif
endmodule
